fetch_unit_btb: RTL and testbench
=================================

# fetch_unit_btb

Parametrised fetch stage with an integrated direct-mapped branch target buffer (BTB) and per-entry 2-bit saturating direction counters. It generates the fetch PC, drives the instruction memory address, predicts next-PC from the BTB, and registers instruction, PC, PC+4 and prediction into the F/D pipeline register. It sits between the hazard unit, instruction memory and decode stage, and accepts resolution and redirect from the execute stage.

## Interface
Parameters:
- XLEN, 32, address/data width.
- BTB_ENTRIES, 16, BTB depth; power of two, ≥2; IDX_W = log2(BTB_ENTRIES).
- RESET_PC, 32'h0, PC loaded on reset.
- CNT_W, 16, width of performance counters.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- imem_addr  out  XLEN  current fetch PC (PCF).
- imem_rdata  in  32  instruction at imem_addr, combinational same cycle.
- stall_f  in  1  hold PC.
- stall_d  in  1  hold F/D register.
- flush_d  in  1  load bubble into F/D register.
- redirect_e  in  1  execute stage detected misprediction.
- redirect_pc_e  in  XLEN  correct next PC on redirect.
- resolve_valid_e  in  1  a branch/jump resolved this cycle.
- resolve_pc_e  in  XLEN  PC of resolved instruction.
- resolve_taken_e  in  1  actual direction.
- resolve_target_e  in  XLEN  actual taken target.
- instr_d, pc_d, pc_plus4_d  out  32/XLEN/XLEN  decode-stage instruction, PC, PC+4.
- pred_taken_d  out  1  prediction made for instr_d.
- pred_target_d  out  XLEN  predicted target for instr_d.
- valid_d  out  1  instr_d is a real instruction.
- mispredict_cnt, branch_cnt  out  CNT_W  saturating performance counters.

## Operation
- BTB entry: valid, tag = pc[XLEN-1:IDX_W+2], target, ctr[1:0]. Index = pc[IDX_W+1:2].
- Lookup (combinational on PCF): hit = valid & tag match; pred_taken = hit & ctr[1]; pred_target = entry target.
- Next PC priority: redirect_e → redirect_pc_e (overrides stall_f); else stall_f → hold; else pred_taken → pred_target; else PCF+4. Adds wrap modulo 2^XLEN.
- BTB update on resolve_valid_e (index/tag from resolve_pc_e):
  - taken & hit: target ← resolve_target_e, ctr saturating +1 (max 2'b11).
  - taken & miss: allocate/overwrite: valid←1, tag, target, ctr←2'b10.
  - not taken & hit: ctr saturating −1 (min 2'b00), target unchanged.
  - not taken & miss: no change.
- F/D register priority: reset > flush_d > stall_d > load. Flush/reset value: instr_d=32'h0000_0013 (NOP), pc_d=0, pc_plus4_d=0, pred_taken_d=0, pred_target_d=0, valid_d=0. Load sets valid_d=1.
- Counters: branch_cnt +1 per resolve_valid_e; mispredict_cnt +1 per redirect_e; both saturate at all-ones, no wrap.
- Reset: PCF=RESET_PC; all BTB valid=0, ctr=2'b01, tags/targets 0; counters 0; F/D as flush value.

## Timing
- Prediction latency zero: BTB read and PC select in the same cycle as fetch; predicted target is PCF next cycle.
- Redirect: redirect_e at cycle N → PCF=redirect_pc_e at N+1. Flushing wrong-path D/E contents is the hazard unit's job via flush_d.
- BTB write at end of cycle; lookup of the same index in the same cycle sees old contents (read-before-write).
- stall_f and stall_d independent; stall_d with flush_d → flush wins.
- rst_n low any cycle discards in-flight state; first fetch at RESET_PC the cycle after rst_n rises.

## Structure
- Package fetch_pkg: NOP encoding, counter constants (CTR_SNT=00, CTR_WNT=01, CTR_WT=10, CTR_ST=11), counter saturating-increment/decrement functions, CNT_W default.
- Sub-module btb_dm: storage, combinational lookup port, update port with counter logic; parameters XLEN, BTB_ENTRIES. The top holds PC register, next-PC mux, F/D register and perf counters.

## Test plan
- Reset: hold rst_n=0 3 cycles with RESET_PC=32'h100 → imem_addr=0x100, valid_d=0, instr_d=0x13, counters 0; then sequential fetch 0x100, 0x104, 0x108.
- Allocate/predict: resolve taken pc=0x110 target=0x200 → next fetch of 0x110 gives pred_taken_d=1, following imem_addr=0x200.
- Counter hysteresis: from ctr=10, one not-taken resolve → ctr 01, 0x110 predicts not-taken (next 0x114); two taken → 11; one not-taken → 10, still taken.
- Redirect priority: redirect_e=1 redirect_pc_e=0x300 with stall_f=1 and pred hit same cycle → imem_addr=0x300 next cycle; mispredict_cnt +1.
- Alias/update collision: BTB_ENTRIES=16, entry for 0x110, resolve taken 0x150 (same index) while fetching 0x110 → lookup that cycle hits old entry; afterward 0x110 misses.
- Flush vs stall: flush_d=1, stall_d=1 → valid_d=0, instr_d=0x13; stall_d alone holds instr_d/pc_d unchanged; counters saturate at 0xFFFF with CNT_W=16.

Source files
------------

// File: rtl/fetch_unit_btb_pkg.sv
// fetch_pkg: shared constants and 2-bit direction counter helpers for the fetch stage
package fetch_pkg;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT = 2'b10;
  localparam logic [1:0] CTR_ST = 2'b11;
  localparam int CNT_W_DEF = 16;
  function automatic logic [1:0] ctr_inc(input logic [1:0] c);
    return c == CTR_ST ? CTR_ST : c + 2'd1;
  endfunction
  function automatic logic [1:0] ctr_dec(input logic [1:0] c);
    return c == CTR_SNT ? CTR_SNT : c - 2'd1;
  endfunction
endpackage

// File: rtl/fetch_unit_btb_btb_dm.sv
// btb_dm: direct-mapped branch target buffer with 2-bit direction counters
// Ports: clk/rst_n (sync active-low); lookup_pc -> pred_taken/pred_target (combinational);
//        upd_valid/upd_pc/upd_taken/upd_target write one entry at the clock edge.
module btb_dm import fetch_pkg::*; #(
  parameter int XLEN = 32,
  parameter int BTB_ENTRIES = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] lookup_pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target
);
  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;
  logic [BTB_ENTRIES-1:0] valid;
  logic [TAG_W-1:0] tag [BTB_ENTRIES];
  logic [XLEN-1:0] target [BTB_ENTRIES];
  logic [1:0] ctr [BTB_ENTRIES];
  logic [IDX_W-1:0] idx, uidx;
  logic hit, uhit;
  logic unused_lsb;
  assign unused_lsb = &{1'b0, lookup_pc[1:0], upd_pc[1:0]};
  assign idx = lookup_pc[IDX_W+1:2];
  assign uidx = upd_pc[IDX_W+1:2];
  assign hit = valid[idx] && tag[idx] == lookup_pc[XLEN-1:IDX_W+2];
  assign uhit = valid[uidx] && tag[uidx] == upd_pc[XLEN-1:IDX_W+2];
  assign pred_taken = hit && ctr[idx][1];
  assign pred_target = target[idx];
  // Lookup reads the pre-edge arrays, so a same-index update is invisible until next cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= '0;
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        tag[i] <= '0;
        target[i] <= '0;
        ctr[i] <= CTR_WNT;
      end
    end else if (upd_valid) begin
      if (upd_taken) begin
        valid[uidx] <= 1'b1;
        tag[uidx] <= upd_pc[XLEN-1:IDX_W+2];
        target[uidx] <= upd_target;
        ctr[uidx] <= uhit ? ctr_inc(ctr[uidx]) : CTR_WT;
      end else if (uhit) begin
        ctr[uidx] <= ctr_dec(ctr[uidx]);
      end
    end
  end
endmodule

// File: rtl/fetch_unit_btb.sv
// fetch_unit_btb: fetch PC generation with BTB prediction, F/D register and perf counters
// Ports: imem_addr/imem_rdata to instruction memory; stall_f/stall_d/flush_d from hazard unit;
//        redirect_* and resolve_* from execute; *_d outputs to decode; saturating perf counters.
module fetch_unit_btb import fetch_pkg::*; #(
  parameter int XLEN = 32,
  parameter int BTB_ENTRIES = 16,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [XLEN-1:0]  imem_addr,
  input  logic [31:0]      imem_rdata,
  input  logic             stall_f,
  input  logic             stall_d,
  input  logic             flush_d,
  input  logic             redirect_e,
  input  logic [XLEN-1:0]  redirect_pc_e,
  input  logic             resolve_valid_e,
  input  logic [XLEN-1:0]  resolve_pc_e,
  input  logic             resolve_taken_e,
  input  logic [XLEN-1:0]  resolve_target_e,
  output logic [31:0]      instr_d,
  output logic [XLEN-1:0]  pc_d,
  output logic [XLEN-1:0]  pc_plus4_d,
  output logic             pred_taken_d,
  output logic [XLEN-1:0]  pred_target_d,
  output logic             valid_d,
  output logic [CNT_W-1:0] mispredict_cnt,
  output logic [CNT_W-1:0] branch_cnt
);
  logic [XLEN-1:0] pcf, next_pc, pred_target;
  logic pred_taken;
  btb_dm #(.XLEN(XLEN), .BTB_ENTRIES(BTB_ENTRIES)) u_btb (
    .clk(clk),
    .rst_n(rst_n),
    .lookup_pc(pcf),
    .pred_taken(pred_taken),
    .pred_target(pred_target),
    .upd_valid(resolve_valid_e),
    .upd_pc(resolve_pc_e),
    .upd_taken(resolve_taken_e),
    .upd_target(resolve_target_e)
  );
  assign imem_addr = pcf;
  // Redirect must win over stall_f so a stalled fetch cannot swallow a misprediction fix.
  always_comb next_pc = redirect_e ? redirect_pc_e : stall_f ? pcf : pred_taken ? pred_target : pcf + XLEN'(4);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pcf <= RESET_PC;
      mispredict_cnt <= '0;
      branch_cnt <= '0;
    end else begin
      pcf <= next_pc;
      if (redirect_e && !(&mispredict_cnt)) mispredict_cnt <= mispredict_cnt + CNT_W'(1);
      if (resolve_valid_e && !(&branch_cnt)) branch_cnt <= branch_cnt + CNT_W'(1);
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n || flush_d) begin
      instr_d <= NOP;
      pc_d <= '0;
      pc_plus4_d <= '0;
      pred_taken_d <= 1'b0;
      pred_target_d <= '0;
      valid_d <= 1'b0;
    end else if (!stall_d) begin
      instr_d <= imem_rdata;
      pc_d <= pcf;
      pc_plus4_d <= pcf + XLEN'(4);
      pred_taken_d <= pred_taken;
      pred_target_d <= pred_target;
      valid_d <= 1'b1;
    end
  end
endmodule

// File: tb/tb_fetch_unit_btb.sv
// tb_fetch_unit_btb: directed stimulus with a per-cycle reference model and literal spot checks
module tb_fetch_unit_btb;
  localparam logic [31:0] RST = 32'h100;
  logic clk = 0, rst_n;
  logic [31:0] imem_addr, imem_rdata, redirect_pc_e, resolve_pc_e, resolve_target_e;
  logic stall_f, stall_d, flush_d, redirect_e, resolve_valid_e, resolve_taken_e;
  logic [31:0] instr_d, pc_d, pc_plus4_d, pred_target_d;
  logic pred_taken_d, valid_d;
  logic [15:0] mispredict_cnt, branch_cnt;
  int passed = 0, total = 0;
  always #5 clk = ~clk;
  assign imem_rdata = imem_addr ^ 32'hA5A5_0000;
  fetch_unit_btb #(.RESET_PC(RST)) dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d),
    .redirect_e(redirect_e), .redirect_pc_e(redirect_pc_e),
    .resolve_valid_e(resolve_valid_e), .resolve_pc_e(resolve_pc_e),
    .resolve_taken_e(resolve_taken_e), .resolve_target_e(resolve_target_e),
    .instr_d(instr_d), .pc_d(pc_d), .pc_plus4_d(pc_plus4_d),
    .pred_taken_d(pred_taken_d), .pred_target_d(pred_target_d), .valid_d(valid_d),
    .mispredict_cnt(mispredict_cnt), .branch_cnt(branch_cnt)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask
  // Reference model: direct-mapped table of 16 entries, counters as plain integers 0..3.
  logic [31:0] m_pc, m_instr, m_pcd, m_pc4, m_tgtd;
  bit m_ptd, m_vd;
  int m_bc, m_mc;
  bit e_v [16];
  logic [31:0] e_tag [16], e_tgt [16];
  int e_ctr [16];
  task automatic model_step();
    int i, u;
    bit h, uh, pt;
    logic [31:0] tg;
    if (!rst_n) begin
      m_pc = RST; m_instr = 32'h13; m_pcd = 0; m_pc4 = 0; m_tgtd = 0; m_ptd = 0; m_vd = 0;
      m_bc = 0; m_mc = 0;
      for (int k = 0; k < 16; k++) begin e_v[k] = 0; e_tag[k] = 0; e_tgt[k] = 0; e_ctr[k] = 1; end
      return;
    end
    i = int'(m_pc[5:2]);
    h = e_v[i] && e_tag[i] == (m_pc >> 6);
    pt = h && e_ctr[i] >= 2;
    tg = e_tgt[i];
    if (flush_d) begin
      m_instr = 32'h13; m_pcd = 0; m_pc4 = 0; m_tgtd = 0; m_ptd = 0; m_vd = 0;
    end else if (!stall_d) begin
      m_instr = m_pc ^ 32'hA5A5_0000; m_pcd = m_pc; m_pc4 = m_pc + 4; m_tgtd = tg; m_ptd = pt; m_vd = 1;
    end
    if (resolve_valid_e) begin
      u = int'(resolve_pc_e[5:2]);
      uh = e_v[u] && e_tag[u] == (resolve_pc_e >> 6);
      if (resolve_taken_e) begin
        e_ctr[u] = uh ? (e_ctr[u] < 3 ? e_ctr[u] + 1 : 3) : 2;
        e_v[u] = 1; e_tag[u] = resolve_pc_e >> 6; e_tgt[u] = resolve_target_e;
      end else if (uh && e_ctr[u] > 0) e_ctr[u]--;
      if (m_bc < 65535) m_bc++;
    end
    if (redirect_e && m_mc < 65535) m_mc++;
    m_pc = redirect_e ? redirect_pc_e : stall_f ? m_pc : pt ? tg : m_pc + 4;
  endtask
  initial forever begin
    @(posedge clk);
    model_step();
    #1;
    chk("m_imem_addr", imem_addr, m_pc);
    chk("m_instr_d", instr_d, m_instr);
    chk("m_pc_d", pc_d, m_pcd);
    chk("m_pc_plus4_d", pc_plus4_d, m_pc4);
    chk("m_pred_taken_d", {31'b0, pred_taken_d}, {31'b0, m_ptd});
    chk("m_pred_target_d", pred_target_d, m_tgtd);
    chk("m_valid_d", {31'b0, valid_d}, {31'b0, m_vd});
    chk("m_branch_cnt", {16'b0, branch_cnt}, m_bc);
    chk("m_mispredict_cnt", {16'b0, mispredict_cnt}, m_mc);
  end
  task automatic cyc(input bit rd, input logic [31:0] rpc, input bit rv, input logic [31:0] rp,
                     input bit tk, input logic [31:0] tt);
    redirect_e = rd; redirect_pc_e = rpc;
    resolve_valid_e = rv; resolve_pc_e = rp; resolve_taken_e = tk; resolve_target_e = tt;
    @(negedge clk);
    {redirect_e, resolve_valid_e, resolve_taken_e, stall_f, stall_d, flush_d} = '0;
    redirect_pc_e = 0; resolve_pc_e = 0; resolve_target_e = 0;
  endtask
  logic [31:0] sv_pc, sv_instr;
  logic [15:0] sv_mc;
  initial begin
    rst_n = 0;
    {redirect_e, resolve_valid_e, resolve_taken_e, stall_f, stall_d, flush_d} = '0;
    redirect_pc_e = 0; resolve_pc_e = 0; resolve_target_e = 0;
    repeat (3) @(negedge clk);
    chk("rst_imem_addr", imem_addr, 32'h100);
    chk("rst_valid_d", {31'b0, valid_d}, 0);
    chk("rst_instr_d", instr_d, 32'h13);
    chk("rst_branch_cnt", {16'b0, branch_cnt}, 0);
    chk("rst_mispredict_cnt", {16'b0, mispredict_cnt}, 0);
    rst_n = 1;
    @(negedge clk);
    chk("seq_104", imem_addr, 32'h104);
    chk("seq_pc_d_100", pc_d, 32'h100);
    cyc(0, 0, 0, 0, 0, 0);
    chk("seq_108", imem_addr, 32'h108);
    cyc(0, 0, 1, 32'h110, 1, 32'h200);
    chk("seq_10c", imem_addr, 32'h10C);
    cyc(0, 0, 0, 0, 0, 0);
    chk("seq_110", imem_addr, 32'h110);
    cyc(0, 0, 0, 0, 0, 0);
    chk("alloc_target", imem_addr, 32'h200);
    chk("alloc_pred_taken_d", {31'b0, pred_taken_d}, 1);
    chk("alloc_pc_d", pc_d, 32'h110);
    cyc(1, 32'h110, 1, 32'h110, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("hyst_wnt", imem_addr, 32'h114);
    cyc(0, 0, 1, 32'h110, 1, 32'h200);
    cyc(1, 32'h110, 1, 32'h110, 1, 32'h200);
    cyc(0, 0, 0, 0, 0, 0);
    chk("hyst_st", imem_addr, 32'h200);
    cyc(1, 32'h110, 1, 32'h110, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("hyst_wt_still", imem_addr, 32'h200);
    cyc(1, 32'h110, 1, 32'h110, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("hyst_back_wnt", imem_addr, 32'h114);
    cyc(1, 32'h110, 1, 32'h110, 1, 32'h200);
    sv_mc = mispredict_cnt;
    stall_f = 1;
    cyc(1, 32'h300, 0, 0, 0, 0);
    chk("redir_over_stall", imem_addr, 32'h300);
    chk("redir_cnt", {16'b0, mispredict_cnt}, {16'b0, sv_mc + 16'd1});
    cyc(1, 32'h110, 0, 0, 0, 0);
    cyc(0, 0, 1, 32'h150, 1, 32'h400);
    chk("alias_old_hit", imem_addr, 32'h200);
    chk("alias_pred_d", {31'b0, pred_taken_d}, 1);
    cyc(1, 32'h110, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("alias_miss", imem_addr, 32'h114);
    flush_d = 1; stall_d = 1;
    cyc(0, 0, 0, 0, 0, 0);
    chk("flush_valid_d", {31'b0, valid_d}, 0);
    chk("flush_instr_d", instr_d, 32'h13);
    cyc(0, 0, 0, 0, 0, 0);
    sv_pc = pc_d; sv_instr = instr_d;
    stall_d = 1;
    cyc(0, 0, 0, 0, 0, 0);
    stall_d = 1;
    cyc(0, 0, 0, 0, 0, 0);
    chk("stall_pc_d", pc_d, sv_pc);
    chk("stall_instr_d", instr_d, sv_instr);
    chk("stall_valid_d", {31'b0, valid_d}, 1);
    redirect_e = 1; redirect_pc_e = 32'h500;
    resolve_valid_e = 1; resolve_pc_e = 32'h700; resolve_taken_e = 0;
    repeat (65540) @(negedge clk);
    cyc(0, 0, 0, 0, 0, 0);
    chk("sat_branch_cnt", {16'b0, branch_cnt}, 32'hFFFF);
    chk("sat_mispredict_cnt", {16'b0, mispredict_cnt}, 32'hFFFF);
    @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
